xadac_vlsu: RTL and testbench
=============================

XADAC_VLSU -- requirements
Module: xadac_vlsu

Interface
REQ-001 SHALL have parameter StoreRsp, default 1, meaning: 1 = stores return a response beat on rsp channel, 0 = stores retire silently after B.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req_valid  input  1  request valid.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_we  input  1  1 = vector store, 0 = vector load.
REQ-007 SHALL have port req_id  input  IdT  transaction id, copied to AXI and response.
REQ-008 SHALL have port req_addr  input  AddrT  byte address, any alignment.
REQ-009 SHALL have port req_data / req_strb  input  VecDataWidth / VecDataWidth/8  store data and byte enables.
REQ-010 SHALL have ports rsp_valid, rsp_ready (out/in, 1), rsp_id (out, IdT), rsp_data (out, VecDataWidth), rsp_we (out, 1), rsp_err (out, 1).
REQ-011 SHALL have port mst  AXI_BUS.Master  VecDataWidth-wide AXI feeding the width-converting wizard stage.

Function
REQ-012 SHALL process one transaction at a time, in order; FSM states IDLE, RD_AR, RD_R, WR_AW_W, WR_B, RSP.
REQ-013 SHALL drive req_ready = (state == IDLE); handshake captures id, addr, we, data, strb into registers.
REQ-014 SHALL go IDLE->RD_AR on load accept; ar_valid high from next cycle, held with stable fields until ar_ready.
REQ-015 SHALL go RD_AR->RD_R on AR handshake; r_ready high only in RD_R; R handshake captures r_data, r_id, r_resp; ->RSP.
REQ-016 SHALL go IDLE->WR_AW_W on store accept; aw_valid and w_valid both rise next cycle; each drops independently after its own handshake; when both done ->WR_B.
REQ-017 SHALL drive b_ready high only in WR_B; B handshake ->RSP if StoreRsp=1, else ->IDLE.
REQ-018 SHALL drive AXI constants: ax_len 0, ax_size $clog2(VecDataWidth/8), ax_burst 0, lock/cache/prot/qos/region/atop/user 0, w_last 1.
REQ-019 SHALL pass req_addr unmodified (misalignment resolved downstream); ax_id = captured id.
REQ-020 SHALL in RSP hold rsp_valid high with stable fields until rsp_ready; rsp_data = captured read data for loads, 0 for stores; then ->IDLE, req_ready high the following cycle.
REQ-021 SHALL drive all AXI valid/ready and rsp_valid from registers (no combinational path req->AXI or AXI->rsp).
REQ-022 SHALL not consume R/B beats outside RD_R/WR_B (ready low); id mismatch on R/B SHALL be ignored (single outstanding).
REQ-023 Minimum load latency: accept cycle 0, ar_valid cycle 1, R at cycle 2 with ready slaves, rsp_valid cycle 3.

Reset
REQ-024 SHALL on rstn low force IDLE and clear all registers immediately, any cycle.
REQ-025 SHALL reset outputs: req_ready 0 during reset then 1, ar/aw/w_valid 0, r/b_ready 0, rsp_valid 0, rsp_data/id/err 0.
REQ-026 SHALL abandon in-flight AXI transaction on reset; no replay after release.

Configuration
REQ-027 Macro XADAC_VLSU_ERR_EN defined: rsp_err = bit 1 of captured r_resp/b_resp (SLVERR/DECERR = 1).
REQ-028 Macro undefined: rsp_err tied 0, r_resp/b_resp ignored, no resp storage.

Verification
REQ-029 Load addr 0x1000 id 3, slave AR ready 0 cycles, R data 0xA5.. -> rsp_valid cycle 3, rsp_id 3, rsp_data matches, ar_addr 0x1000.
REQ-030 Store addr 0x1003 strb all-ones, aw_ready 5 cycles before w_ready -> aw_valid drops after AW beat, w_valid stays until W beat, exactly one AW/W/B, rsp_we 1.
REQ-031 StoreRsp=0 store -> no rsp_valid, req_ready high cycle after B handshake.
REQ-032 With XADAC_VLSU_ERR_EN, r_resp 2'b10 -> rsp_err 1; without macro -> rsp_err 0.
REQ-033 rstn low while in RD_R -> next cycle all valids 0, state IDLE; stray R beat after release not consumed (r_ready 0).
REQ-034 rsp_ready low 10 cycles -> rsp fields stable, req_ready 0 throughout, back-to-back next load accepted cycle after handshake.

Source files
------------

// File: rtl/xadac_vlsu.sv
// ============================================================================
// Module   : xadac_vlsu
// Brief    : Single-outstanding vector load/store unit bridging a req/rsp
//            port onto a VecDataWidth-wide AXI master. Optional feature macro:
//            XADAC_VLSU_ERR_EN (report AXI SLVERR/DECERR on rsp_err).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xadac_vlsu #(
  parameter int unsigned StoreRsp     = 1,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned VecDataWidth = 64,
  parameter int unsigned UserWidth    = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [IdWidth-1:0]        req_id,
  input  logic [AddrWidth-1:0]      req_addr,
  input  logic [VecDataWidth-1:0]   req_data,
  input  logic [VecDataWidth/8-1:0] req_strb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IdWidth-1:0]        rsp_id,
  output logic [VecDataWidth-1:0]   rsp_data,
  output logic                      rsp_we,
  output logic                      rsp_err,
  output logic [IdWidth-1:0]        mst_aw_id,
  output logic [AddrWidth-1:0]      mst_aw_addr,
  output logic [7:0]                mst_aw_len,
  output logic [2:0]                mst_aw_size,
  output logic [1:0]                mst_aw_burst,
  output logic                      mst_aw_lock,
  output logic [3:0]                mst_aw_cache,
  output logic [2:0]                mst_aw_prot,
  output logic [3:0]                mst_aw_qos,
  output logic [3:0]                mst_aw_region,
  output logic [5:0]                mst_aw_atop,
  output logic [UserWidth-1:0]      mst_aw_user,
  output logic                      mst_aw_valid,
  input  logic                      mst_aw_ready,
  output logic [VecDataWidth-1:0]   mst_w_data,
  output logic [VecDataWidth/8-1:0] mst_w_strb,
  output logic                      mst_w_last,
  output logic [UserWidth-1:0]      mst_w_user,
  output logic                      mst_w_valid,
  input  logic                      mst_w_ready,
  input  logic [IdWidth-1:0]        mst_b_id,
  input  logic [1:0]                mst_b_resp,
  input  logic [UserWidth-1:0]      mst_b_user,
  input  logic                      mst_b_valid,
  output logic                      mst_b_ready,
  output logic [IdWidth-1:0]        mst_ar_id,
  output logic [AddrWidth-1:0]      mst_ar_addr,
  output logic [7:0]                mst_ar_len,
  output logic [2:0]                mst_ar_size,
  output logic [1:0]                mst_ar_burst,
  output logic                      mst_ar_lock,
  output logic [3:0]                mst_ar_cache,
  output logic [2:0]                mst_ar_prot,
  output logic [3:0]                mst_ar_qos,
  output logic [3:0]                mst_ar_region,
  output logic [UserWidth-1:0]      mst_ar_user,
  output logic                      mst_ar_valid,
  input  logic                      mst_ar_ready,
  input  logic [IdWidth-1:0]        mst_r_id,
  input  logic [VecDataWidth-1:0]   mst_r_data,
  input  logic [1:0]                mst_r_resp,
  input  logic                      mst_r_last,
  input  logic [UserWidth-1:0]      mst_r_user,
  input  logic                      mst_r_valid,
  output logic                      mst_r_ready
);

  localparam logic [2:0] AxSize = 3'($clog2(VecDataWidth / 8));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_AR   = 3'd1,
    RD_R    = 3'd2,
    WR_AW_W = 3'd3,
    WR_B    = 3'd4,
    RSP     = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic                      req_ready_q, ar_valid_q, aw_valid_q, w_valid_q;
  logic                      ar_valid_d, aw_valid_d, w_valid_d;
  logic                      r_ready_q, b_ready_q, rsp_valid_q;
  logic                      we_q;
  logic [IdWidth-1:0]        id_q;
  logic [AddrWidth-1:0]      addr_q;
  logic [VecDataWidth-1:0]   data_q, rdata_q;
  logic [VecDataWidth/8-1:0] strb_q;
  logic                      req_hs, r_hs, b_hs;

  assign req_hs = (state_q == IDLE) && req_valid && req_ready_q;
  assign r_hs   = (state_q == RD_R) && mst_r_valid && r_ready_q;
  assign b_hs   = (state_q == WR_B) && mst_b_valid && b_ready_q;

  always_comb begin
    state_d    = state_q;
    ar_valid_d = ar_valid_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          state_d    = req_we ? WR_AW_W : RD_AR;
          ar_valid_d = !req_we;
          aw_valid_d = req_we;
          w_valid_d  = req_we;
        end
      end
      RD_AR: begin
        if (ar_valid_q && mst_ar_ready) begin
          ar_valid_d = 1'b0;
          state_d    = RD_R;
        end
      end
      RD_R: if (r_hs) state_d = RSP;
      WR_AW_W: begin
        // AW and W complete independently; B is awaited only once both are gone.
        if (aw_valid_q && mst_aw_ready) aw_valid_d = 1'b0;
        if (w_valid_q && mst_w_ready) w_valid_d = 1'b0;
        if (!aw_valid_d && !w_valid_d) state_d = WR_B;
      end
      WR_B: if (b_hs) state_d = (StoreRsp != 0) ? RSP : IDLE;
      RSP: if (rsp_valid_q && rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      ar_valid_q  <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      r_ready_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      we_q        <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == IDLE);
      ar_valid_q  <= ar_valid_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      r_ready_q   <= (state_d == RD_R);
      b_ready_q   <= (state_d == WR_B);
      rsp_valid_q <= (state_d == RSP);
      if (req_hs) begin
        we_q   <= req_we;
        id_q   <= req_id;
        addr_q <= req_addr;
        data_q <= req_data;
        strb_q <= req_strb;
      end
      if (r_hs) rdata_q <= mst_r_data;
    end
  end

`ifdef XADAC_VLSU_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (req_hs) begin
      err_q <= 1'b0;
    end else if (r_hs) begin
      err_q <= mst_r_resp[1];
    end else if (b_hs) begin
      err_q <= mst_b_resp[1];
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Single outstanding transaction: returned ids and beat sidebands carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{mst_r_id, mst_r_last, mst_r_user, mst_r_resp,
                           mst_b_id, mst_b_user, mst_b_resp};

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_we    = we_q;
  assign rsp_data  = we_q ? '0 : rdata_q;

  assign mst_aw_id     = id_q;
  assign mst_aw_addr   = addr_q;
  assign mst_aw_len    = 8'd0;
  assign mst_aw_size   = AxSize;
  assign mst_aw_burst  = 2'b00;
  assign mst_aw_lock   = 1'b0;
  assign mst_aw_cache  = 4'd0;
  assign mst_aw_prot   = 3'd0;
  assign mst_aw_qos    = 4'd0;
  assign mst_aw_region = 4'd0;
  assign mst_aw_atop   = 6'd0;
  assign mst_aw_user   = '0;
  assign mst_aw_valid  = aw_valid_q;

  assign mst_w_data    = data_q;
  assign mst_w_strb    = strb_q;
  assign mst_w_last    = 1'b1;
  assign mst_w_user    = '0;
  assign mst_w_valid   = w_valid_q;
  assign mst_b_ready   = b_ready_q;

  assign mst_ar_id     = id_q;
  assign mst_ar_addr   = addr_q;
  assign mst_ar_len    = 8'd0;
  assign mst_ar_size   = AxSize;
  assign mst_ar_burst  = 2'b00;
  assign mst_ar_lock   = 1'b0;
  assign mst_ar_cache  = 4'd0;
  assign mst_ar_prot   = 3'd0;
  assign mst_ar_qos    = 4'd0;
  assign mst_ar_region = 4'd0;
  assign mst_ar_user   = '0;
  assign mst_ar_valid  = ar_valid_q;
  assign mst_r_ready   = r_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_xadac_vlsu.sv
// ============================================================================
// Module   : tb_xadac_vlsu
// Brief    : Self-checking bench for xadac_vlsu (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xadac_vlsu;

`ifdef XADAC_VLSU_ERR_EN
  localparam bit ErrOn = 1'b1;
`else
  localparam bit ErrOn = 1'b0;
`endif

  logic        clk, rstn;
  logic        req_valid, req_valid0, req_we, rsp_ready;
  logic [3:0]  req_id;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [7:0]  req_strb;
  logic        mst_aw_ready, mst_w_ready, mst_b_valid, mst_ar_ready, mst_r_valid, mst_r_last;
  logic [3:0]  mst_b_id, mst_r_id;
  logic [1:0]  mst_b_resp, mst_r_resp;
  logic [0:0]  mst_b_user, mst_r_user;
  logic [63:0] mst_r_data;

  logic        req_ready, rsp_valid, rsp_we, rsp_err;
  logic [3:0]  rsp_id;
  logic [63:0] rsp_data;
  logic [3:0]  mst_aw_id, mst_ar_id, mst_aw_cache, mst_aw_qos, mst_aw_region;
  logic [3:0]  mst_ar_cache, mst_ar_qos, mst_ar_region;
  logic [31:0] mst_aw_addr, mst_ar_addr;
  logic [7:0]  mst_aw_len, mst_ar_len, mst_w_strb;
  logic [2:0]  mst_aw_size, mst_ar_size, mst_aw_prot, mst_ar_prot;
  logic [1:0]  mst_aw_burst, mst_ar_burst;
  logic        mst_aw_lock, mst_ar_lock, mst_aw_valid, mst_ar_valid;
  logic [5:0]  mst_aw_atop;
  logic [0:0]  mst_aw_user, mst_ar_user, mst_w_user;
  logic [63:0] mst_w_data;
  logic        mst_w_last, mst_w_valid, mst_b_ready, mst_r_ready;

  // Outputs of the StoreRsp=0 instance
  logic        d0_req_ready, d0_rsp_valid, d0_rsp_we, d0_rsp_err;
  logic [3:0]  d0_rsp_id, d0_aw_id, d0_ar_id, d0_aw_cache, d0_aw_qos, d0_aw_region;
  logic [3:0]  d0_ar_cache, d0_ar_qos, d0_ar_region;
  logic [63:0] d0_rsp_data, d0_w_data;
  logic [31:0] d0_aw_addr, d0_ar_addr;
  logic [7:0]  d0_aw_len, d0_ar_len, d0_w_strb;
  logic [2:0]  d0_aw_size, d0_ar_size, d0_aw_prot, d0_ar_prot;
  logic [1:0]  d0_aw_burst, d0_ar_burst;
  logic        d0_aw_lock, d0_ar_lock, d0_aw_valid, d0_ar_valid;
  logic [5:0]  d0_aw_atop;
  logic [0:0]  d0_aw_user, d0_ar_user, d0_w_user;
  logic        d0_w_last, d0_w_valid, d0_b_ready, d0_r_ready;

  xadac_vlsu #(.StoreRsp(1), .IdWidth(4), .AddrWidth(32), .VecDataWidth(64), .UserWidth(1)) u_dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_id(req_id),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_we(rsp_we), .rsp_err(rsp_err),
    .mst_aw_id(mst_aw_id), .mst_aw_addr(mst_aw_addr), .mst_aw_len(mst_aw_len),
    .mst_aw_size(mst_aw_size), .mst_aw_burst(mst_aw_burst), .mst_aw_lock(mst_aw_lock),
    .mst_aw_cache(mst_aw_cache), .mst_aw_prot(mst_aw_prot), .mst_aw_qos(mst_aw_qos),
    .mst_aw_region(mst_aw_region), .mst_aw_atop(mst_aw_atop), .mst_aw_user(mst_aw_user),
    .mst_aw_valid(mst_aw_valid), .mst_aw_ready(mst_aw_ready),
    .mst_w_data(mst_w_data), .mst_w_strb(mst_w_strb), .mst_w_last(mst_w_last),
    .mst_w_user(mst_w_user), .mst_w_valid(mst_w_valid), .mst_w_ready(mst_w_ready),
    .mst_b_id(mst_b_id), .mst_b_resp(mst_b_resp), .mst_b_user(mst_b_user),
    .mst_b_valid(mst_b_valid), .mst_b_ready(mst_b_ready),
    .mst_ar_id(mst_ar_id), .mst_ar_addr(mst_ar_addr), .mst_ar_len(mst_ar_len),
    .mst_ar_size(mst_ar_size), .mst_ar_burst(mst_ar_burst), .mst_ar_lock(mst_ar_lock),
    .mst_ar_cache(mst_ar_cache), .mst_ar_prot(mst_ar_prot), .mst_ar_qos(mst_ar_qos),
    .mst_ar_region(mst_ar_region), .mst_ar_user(mst_ar_user),
    .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready),
    .mst_r_id(mst_r_id), .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp),
    .mst_r_last(mst_r_last), .mst_r_user(mst_r_user), .mst_r_valid(mst_r_valid),
    .mst_r_ready(mst_r_ready)
  );

  xadac_vlsu #(.StoreRsp(0), .IdWidth(4), .AddrWidth(32), .VecDataWidth(64), .UserWidth(1)) u_dut0 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid0), .req_ready(d0_req_ready), .req_we(req_we), .req_id(req_id),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .rsp_valid(d0_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d0_rsp_id), .rsp_data(d0_rsp_data),
    .rsp_we(d0_rsp_we), .rsp_err(d0_rsp_err),
    .mst_aw_id(d0_aw_id), .mst_aw_addr(d0_aw_addr), .mst_aw_len(d0_aw_len),
    .mst_aw_size(d0_aw_size), .mst_aw_burst(d0_aw_burst), .mst_aw_lock(d0_aw_lock),
    .mst_aw_cache(d0_aw_cache), .mst_aw_prot(d0_aw_prot), .mst_aw_qos(d0_aw_qos),
    .mst_aw_region(d0_aw_region), .mst_aw_atop(d0_aw_atop), .mst_aw_user(d0_aw_user),
    .mst_aw_valid(d0_aw_valid), .mst_aw_ready(mst_aw_ready),
    .mst_w_data(d0_w_data), .mst_w_strb(d0_w_strb), .mst_w_last(d0_w_last),
    .mst_w_user(d0_w_user), .mst_w_valid(d0_w_valid), .mst_w_ready(mst_w_ready),
    .mst_b_id(mst_b_id), .mst_b_resp(mst_b_resp), .mst_b_user(mst_b_user),
    .mst_b_valid(mst_b_valid), .mst_b_ready(d0_b_ready),
    .mst_ar_id(d0_ar_id), .mst_ar_addr(d0_ar_addr), .mst_ar_len(d0_ar_len),
    .mst_ar_size(d0_ar_size), .mst_ar_burst(d0_ar_burst), .mst_ar_lock(d0_ar_lock),
    .mst_ar_cache(d0_ar_cache), .mst_ar_prot(d0_ar_prot), .mst_ar_qos(d0_ar_qos),
    .mst_ar_region(d0_ar_region), .mst_ar_user(d0_ar_user),
    .mst_ar_valid(d0_ar_valid), .mst_ar_ready(mst_ar_ready),
    .mst_r_id(mst_r_id), .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp),
    .mst_r_last(mst_r_last), .mst_r_user(mst_r_user), .mst_r_valid(mst_r_valid),
    .mst_r_ready(d0_r_ready)
  );

  typedef struct {
    bit          we;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    int          ar_dly, aw_dly, w_dly, r_dly, b_dly;
    logic [1:0]  resp;
    int          rsp_dly;
    logic [63:0] exp_data;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    bit          we;
    bit          err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[8];
  vec_t v0;
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit we, input logic [3:0] id, input logic [31:0] addr,
                              input logic [63:0] data, input logic [7:0] strb,
                              input int ar, input int aw, input int w, input int r, input int b,
                              input logic [1:0] resp, input int rsp_dly,
                              input logic [63:0] exp_data, input bit exp_err, input int exp_lat);
    vec_t t;
    t.we = we; t.id = id; t.addr = addr; t.data = data; t.strb = strb;
    t.ar_dly = ar; t.aw_dly = aw; t.w_dly = w; t.r_dly = r; t.b_dly = b;
    t.resp = resp; t.rsp_dly = rsp_dly;
    t.exp_data = exp_data; t.exp_err = exp_err; t.exp_lat = exp_lat;
    return t;
  endfunction

  task automatic idle_slave();
    mst_ar_ready = 1'b0; mst_aw_ready = 1'b0; mst_w_ready = 1'b0;
    mst_r_valid = 1'b0; mst_b_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input bit use0);
    int   cyc = 0, first_rsp = -1;
    int   ar_w = 0, aw_w = 0, w_w = 0, r_w = 0, b_w = 0, rsp_w = 0;
    int   n_ar = 0, n_aw = 0, n_w = 0, n_r = 0, n_b = 0;
    bit   fin = 0, aw_done = 0, w_done = 0, b0_done = 0;
    bit   ar_hs, aw_hs, w_hs, r_hs, b_hs, b_hs0, rsp_hs;
    exp_t e;
    for (int k = 0; k < 50 && !req_ready; k++) begin @(posedge clk); #1; end
    chk("req_ready_idle", req_ready, 1);
    if (use0) chk("d0_req_ready_idle", d0_req_ready, 1);
    req_valid = 1'b1; req_valid0 = use0;
    req_we = v.we; req_id = v.id; req_addr = v.addr; req_data = v.data; req_strb = v.strb;
    e.id = v.id; e.data = v.exp_data; e.we = v.we; e.err = v.exp_err; e.lat = v.exp_lat;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid0 = 1'b0; cyc = 1;
    for (int k = 0; k < 200 && !fin; k++) begin
      chk("req_ready_busy", req_ready, 0);
      idle_slave();
      if (mst_ar_valid) begin
        if (ar_w >= v.ar_dly) begin
          mst_ar_ready = 1'b1;
          chk("ar_addr", mst_ar_addr, v.addr);
          chk("ar_id", mst_ar_id, v.id);
          chk("ar_len_size_burst", {mst_ar_len, mst_ar_size, mst_ar_burst}, {8'd0, 3'd3, 2'd0});
          chk("ar_misc", {mst_ar_lock, mst_ar_cache, mst_ar_prot, mst_ar_qos, mst_ar_region, mst_ar_user}, 0);
        end else ar_w++;
      end
      if (mst_aw_valid) begin
        if (aw_w >= v.aw_dly) begin
          mst_aw_ready = 1'b1;
          chk("aw_addr", mst_aw_addr, v.addr);
          chk("aw_id", mst_aw_id, v.id);
          chk("aw_len_size_burst", {mst_aw_len, mst_aw_size, mst_aw_burst}, {8'd0, 3'd3, 2'd0});
          chk("aw_misc", {mst_aw_lock, mst_aw_cache, mst_aw_prot, mst_aw_qos, mst_aw_region,
                          mst_aw_atop, mst_aw_user}, 0);
        end else aw_w++;
      end
      if (mst_w_valid) begin
        if (w_w >= v.w_dly) begin
          mst_w_ready = 1'b1;
          chk("w_data", mst_w_data, v.data);
          chk("w_strb_last_user", {mst_w_strb, mst_w_last, mst_w_user}, {v.strb, 1'b1, 1'b0});
        end else w_w++;
      end
      if (mst_r_ready) begin
        if (r_w >= v.r_dly) begin
          mst_r_valid = 1'b1; mst_r_data = v.data; mst_r_resp = v.resp; mst_r_id = ~v.id;
        end else r_w++;
      end
      if (mst_b_ready) begin
        if (b_w >= v.b_dly) begin
          mst_b_valid = 1'b1; mst_b_resp = v.resp; mst_b_id = ~v.id;
        end else b_w++;
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("sb_not_empty", 0, 1);
        end else begin
          if (first_rsp < 0) begin
            first_rsp = cyc;
            chk("rsp_latency", first_rsp, sb[0].lat);
          end
          chk("rsp_id", rsp_id, sb[0].id);
          chk("rsp_data", rsp_data, sb[0].data);
          chk("rsp_we", rsp_we, sb[0].we);
          chk("rsp_err", rsp_err, sb[0].err);
        end
        if (rsp_w >= v.rsp_dly) rsp_ready = 1'b1;
        else rsp_w++;
      end
      if (use0) begin
        chk("d0_no_rsp", d0_rsp_valid, 0);
        if (!b0_done) chk("d0_req_ready_busy", d0_req_ready, 0);
      end
      ar_hs  = mst_ar_valid && mst_ar_ready;
      aw_hs  = mst_aw_valid && mst_aw_ready;
      w_hs   = mst_w_valid && mst_w_ready;
      r_hs   = mst_r_valid && mst_r_ready;
      b_hs   = mst_b_valid && mst_b_ready;
      b_hs0  = use0 && mst_b_valid && d0_b_ready;
      rsp_hs = rsp_valid && rsp_ready;
      n_ar += int'(ar_hs); n_aw += int'(aw_hs); n_w += int'(w_hs);
      n_r += int'(r_hs); n_b += int'(b_hs);
      @(posedge clk); #1;
      cyc++;
      if (aw_hs && !w_hs && !w_done) begin
        chk("aw_valid_drop", mst_aw_valid, 0);
        chk("w_valid_hold", mst_w_valid, 1);
      end
      aw_done |= aw_hs; w_done |= w_hs;
      if (b_hs0) begin
        b0_done = 1'b1;
        chk("d0_req_ready_after_b", d0_req_ready, 1);
      end
      if (rsp_hs) begin
        fin = 1'b1;
        if (sb.size() > 0) e = sb.pop_front();
        chk("req_ready_after_rsp", req_ready, 1);
      end
    end
    idle_slave();
    chk("txn_done", fin, 1);
    chk("beats_ar_r", {n_ar[7:0], n_r[7:0]}, v.we ? 16'h0000 : 16'h0101);
    chk("beats_aw_w_b", {n_aw[7:0], n_w[7:0], n_b[7:0]}, v.we ? 24'h010101 : 24'h000000);
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = 1'b0; req_valid0 = 1'b0; req_we = 1'b0; req_id = '0;
    req_addr = '0; req_data = '0; req_strb = '0;
    mst_r_data = '0; mst_r_resp = '0; mst_r_id = '0; mst_r_last = 1'b1; mst_r_user = '0;
    mst_b_resp = '0; mst_b_id = '0; mst_b_user = '0;
    idle_slave();

    tbl[0] = mk(0, 4'h3, 32'h0000_1000, 64'hA5A5_A5A5_A5A5_A5A5, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0,
                64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 3);
    tbl[1] = mk(1, 4'h5, 32'h0000_1003, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 5, 0, 0, 2'b00, 0,
                64'h0, 1'b0, 8);
    tbl[2] = mk(0, 4'h7, 32'h0000_2001, 64'hDEAD_BEEF_CAFE_F00D, 8'h00, 2, 0, 0, 3, 0, 2'b10, 0,
                64'hDEAD_BEEF_CAFE_F00D, ErrOn, 8);
    tbl[3] = mk(1, 4'h1, 32'hFFFF_FFF8, 64'h1111_2222_3333_4444, 8'h0F, 0, 4, 0, 0, 2, 2'b11, 0,
                64'h0, ErrOn, 9);
    tbl[4] = mk(0, 4'hF, 32'h0000_0010, 64'h0F0F_0F0F_F0F0_F0F0, 8'h00, 0, 0, 0, 0, 0, 2'b01, 10,
                64'h0F0F_0F0F_F0F0_F0F0, 1'b0, 3);
    tbl[5] = mk(0, 4'h2, 32'h0000_0018, 64'h5A5A_1234_5A5A_5678, 8'h00, 1, 0, 0, 1, 0, 2'b00, 0,
                64'h5A5A_1234_5A5A_5678, 1'b0, 5);
    tbl[6] = mk(1, 4'h9, 32'h0000_0040, 64'hFEDC_BA98_7654_3210, 8'h81, 0, 2, 2, 0, 1, 2'b01, 3,
                64'h0, 1'b0, 6);
    tbl[7] = mk(0, 4'hA, 32'h0000_3000, 64'h0BAD_F00D_1357_9BDF, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0,
                64'h0BAD_F00D_1357_9BDF, 1'b0, 3);
    v0     = mk(1, 4'h4, 32'h0000_2000, 64'h7777_8888_9999_AAAA, 8'hFF, 0, 1, 0, 0, 1, 2'b00, 0,
                64'h0, 1'b0, 5);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_valids", {mst_ar_valid, mst_aw_valid, mst_w_valid, mst_r_ready, mst_b_ready, rsp_valid}, 0);
    chk("rst_rsp_fields", {rsp_data, rsp_id, rsp_err}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_rst", req_ready, 1);

    for (int i = 0; i < 7; i++) run_txn(tbl[i], 1'b0);

    run_txn(v0, 1'b1);

    // Reset while waiting for R, then a stray R beat after release.
    for (int k = 0; k < 20 && !req_ready; k++) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_we = 1'b0; req_id = 4'h6; req_addr = 32'h0000_5000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rr_ar_valid", mst_ar_valid, 1);
    mst_ar_ready = 1'b1;
    @(posedge clk); #1;
    mst_ar_ready = 1'b0;
    chk("rr_in_rd_r", mst_r_ready, 1);
    rstn = 1'b0;
    #1;
    chk("rr_async_clear", {mst_ar_valid, mst_aw_valid, mst_w_valid, mst_r_ready, mst_b_ready,
                           rsp_valid, req_ready}, 0);
    @(posedge clk); #1;
    chk("rr_held_clear", {mst_ar_valid, mst_r_ready, rsp_valid, req_ready}, 0);
    rstn = 1'b1;
    mst_r_valid = 1'b1; mst_r_data = 64'hBAD0_BAD0_BAD0_BAD0; mst_r_id = 4'h6;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rr_stray_r_ready", mst_r_ready, 0);
      chk("rr_no_replay", {mst_ar_valid, rsp_valid}, 0);
      chk("rr_idle", req_ready, 1);
    end
    mst_r_valid = 1'b0;

    run_txn(tbl[7], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
